tl_math_sched: RTL and testbench

//  Round-robin scheduler for the shared top-level math datapath: add, sub, L_mult units and the scratch memory port.

---
 rtl/tl_math_sched.sv | 202 ++++++++++++++++++++
 tb/tb_tl_math_sched.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_math_sched.sv
// tl_math_sched: round-robin owner arbiter for the shared add/sub/L_mult units
// and the scratch memory port. Section start requests are queued as pending
// bits. One section at a time is started, its buses are routed to the shared
// units, and the section is released on its own done pulse or when the
// watchdog expires.
//
// Pulse protocol: req, sec_done, sec_start and sec_done_out are single-cycle
// strobes sampled on the rising clock edge. There is no back-pressure. A
// request is held in pending until it is granted, and repeat requests merge.
module tl_math_sched #(
    parameter int NREQ    = 4,
    parameter int AW      = 12,
    parameter int TIMEOUT = 1024,
    localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int WW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   sec_done,
    output logic [NREQ-1:0]   sec_start,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic [IW-1:0]     done_id,
    output logic              sec_done_out,
    output logic              timeout_err,
    input  logic [NREQ*16-1:0] sec_add_a,
    input  logic [NREQ*16-1:0] sec_add_b,
    input  logic [NREQ*16-1:0] sec_sub_a,
    input  logic [NREQ*16-1:0] sec_sub_b,
    input  logic [NREQ*16-1:0] sec_mult_a,
    input  logic [NREQ*16-1:0] sec_mult_b,
    input  logic [NREQ*AW-1:0] sec_rd_addr,
    input  logic [NREQ*AW-1:0] sec_wr_addr,
    input  logic [NREQ*32-1:0] sec_mem_out,
    input  logic [NREQ-1:0]   sec_wr_en,
    output logic [15:0]       addOutA,
    output logic [15:0]       addOutB,
    output logic [15:0]       subOutA,
    output logic [15:0]       subOutB,
    output logic [15:0]       L_multOutA,
    output logic [15:0]       L_multOutB,
    output logic [AW-1:0]     memReadAddr,
    output logic [AW-1:0]     memWriteAddr,
    output logic [31:0]       memOut,
    output logic              memWriteEn,
    output logic [1:0]        state_dbg,
    output logic [NREQ-1:0]   pending_dbg
);

    localparam int SW = IW + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_START   = 2'd1;
    localparam logic [1:0] S_BUSY    = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    logic [1:0]      state;
    logic [NREQ-1:0] pending;
    logic [NREQ-1:0] grant_q;
    logic [NREQ-1:0] clr_mask;
    logic [IW-1:0]   gid;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   next_ptr;
    logic            pick_valid;
    logic [SW-1:0]   sum;
    logic [WW-1:0]   wdog;
    logic            timeout_q;
    logic [IW-1:0]   done_id_q;
    logic            done_hit;
    logic            wdog_expired;

    // First pending section at or after rr_ptr, wrapping; the descending scan
    // lets the smallest rotational offset win.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        sum        = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            sum = {1'b0, rr_ptr} + SW'(i);
            if (sum >= SW'(NREQ)) begin
                sum = sum - SW'(NREQ);
            end
            if (pending[sum[IW-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = sum[IW-1:0];
            end
        end
    end

    // Grant-side decode: pending clear mask, owner finish, watchdog expiry.
    always_comb begin
        clr_mask     = '0;
        if (state == S_IDLE && pick_valid) begin
            clr_mask = NREQ'(1) << pick_idx;
        end
        done_hit     = (state == S_BUSY) && sec_done[gid];
        wdog_expired = (state == S_BUSY) && !done_hit && (wdog == WW'(TIMEOUT - 1));
        next_ptr     = (gid == IW'(NREQ - 1)) ? '0 : gid + 1'b1;
    end

    // Request queue: a grant clears first and a same-cycle request sets again.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | req;
        end
    end

    // Ownership FSM with watchdog and round-robin pointer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            grant_q   <= '0;
            gid       <= '0;
            rr_ptr    <= '0;
            wdog      <= '0;
            done_id_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        grant_q <= NREQ'(1) << pick_idx;
                        gid     <= pick_idx;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    wdog  <= '0;
                    state <= S_BUSY;
                end
                S_BUSY: begin
                    if (done_hit) begin
                        done_id_q <= gid;
                        rr_ptr    <= next_ptr;
                        grant_q   <= '0;
                        state     <= S_RELEASE;
                    end else if (wdog_expired) begin
                        timeout_q <= 1'b1;
                        rr_ptr    <= next_ptr;
                        grant_q   <= '0;
                        state     <= S_RELEASE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                S_RELEASE: begin
                    grant_q <= '0;
                    state   <= S_IDLE;
                end
                default: begin
                    grant_q <= '0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    // Shared-bus routing: OR of the owner's slices, all zero when nobody owns.
    always_comb begin
        addOutA      = '0;
        addOutB      = '0;
        subOutA      = '0;
        subOutB      = '0;
        L_multOutA   = '0;
        L_multOutB   = '0;
        memReadAddr  = '0;
        memWriteAddr = '0;
        memOut       = '0;
        memWriteEn   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_q[k]) begin
                addOutA      = addOutA      | sec_add_a[16*k +: 16];
                addOutB      = addOutB      | sec_add_b[16*k +: 16];
                subOutA      = subOutA      | sec_sub_a[16*k +: 16];
                subOutB      = subOutB      | sec_sub_b[16*k +: 16];
                L_multOutA   = L_multOutA   | sec_mult_a[16*k +: 16];
                L_multOutB   = L_multOutB   | sec_mult_b[16*k +: 16];
                memReadAddr  = memReadAddr  | sec_rd_addr[AW*k +: AW];
                memWriteAddr = memWriteAddr | sec_wr_addr[AW*k +: AW];
                memOut       = memOut       | sec_mem_out[32*k +: 32];
                memWriteEn   = memWriteEn   | sec_wr_en[k];
            end
        end
    end

    // Status and strobe outputs.
    always_comb begin
        sec_start    = (state == S_START) ? grant_q : '0;
        grant        = grant_q;
        busy         = (state != S_IDLE);
        done_id      = done_id_q;
        sec_done_out = done_hit;
        timeout_err  = timeout_q;
        state_dbg    = state;
        pending_dbg  = pending;
    end

endmodule

// File: tb/tb_tl_math_sched.sv
// Bench for tl_math_sched: table of request patterns with expected service
// order, plus hand sequences for latency, re-request, watchdog and reset.
module tb_tl_math_sched;

    localparam int NREQ    = 4;
    localparam int AW      = 12;
    localparam int TIMEOUT = 16;

    logic                clock = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req;
    logic [NREQ-1:0]     sec_done;
    logic [NREQ-1:0]     sec_start;
    logic [NREQ-1:0]     grant;
    logic                busy;
    logic [1:0]          done_id;
    logic                sec_done_out;
    logic                timeout_err;
    logic [NREQ*16-1:0]  sec_add_a, sec_add_b, sec_sub_a, sec_sub_b, sec_mult_a, sec_mult_b;
    logic [NREQ*AW-1:0]  sec_rd_addr, sec_wr_addr;
    logic [NREQ*32-1:0]  sec_mem_out;
    logic [NREQ-1:0]     sec_wr_en;
    logic [15:0]         addOutA, addOutB, subOutA, subOutB, L_multOutA, L_multOutB;
    logic [AW-1:0]       memReadAddr, memWriteAddr;
    logic [31:0]         memOut;
    logic                memWriteEn;
    logic [1:0]          state_dbg;
    logic [NREQ-1:0]     pending_dbg;

    tl_math_sched #(.NREQ(NREQ), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .req(req), .sec_done(sec_done),
        .sec_start(sec_start), .grant(grant), .busy(busy), .done_id(done_id),
        .sec_done_out(sec_done_out), .timeout_err(timeout_err),
        .sec_add_a(sec_add_a), .sec_add_b(sec_add_b),
        .sec_sub_a(sec_sub_a), .sec_sub_b(sec_sub_b),
        .sec_mult_a(sec_mult_a), .sec_mult_b(sec_mult_b),
        .sec_rd_addr(sec_rd_addr), .sec_wr_addr(sec_wr_addr),
        .sec_mem_out(sec_mem_out), .sec_wr_en(sec_wr_en),
        .addOutA(addOutA), .addOutB(addOutB), .subOutA(subOutA), .subOutB(subOutB),
        .L_multOutA(L_multOutA), .L_multOutB(L_multOutB),
        .memReadAddr(memReadAddr), .memWriteAddr(memWriteAddr),
        .memOut(memOut), .memWriteEn(memWriteEn),
        .state_dbg(state_dbg), .pending_dbg(pending_dbg)
    );

    // Clock / reset-free timebase
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] req;
        int         n;
        logic [7:0] order;   // service order, first id in [1:0]
    } vec_t;

    vec_t       vecs[7];
    logic [1:0] exp_q[$];
    int         n_checks = 0;
    int         n_err    = 0;
    int         starts   = 0;
    int         done_outs = 0;
    int         lat[NREQ];
    bit         hang[NREQ];
    logic [NREQ-1:0] extra_done;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic randomize_buses();
        for (int k = 0; k < NREQ; k++) begin
            sec_add_a[16*k +: 16]   = 16'($urandom);
            sec_add_b[16*k +: 16]   = 16'($urandom);
            sec_sub_a[16*k +: 16]   = 16'($urandom);
            sec_sub_b[16*k +: 16]   = 16'($urandom);
            sec_mult_a[16*k +: 16]  = 16'($urandom);
            sec_mult_b[16*k +: 16]  = 16'($urandom);
            sec_rd_addr[AW*k +: AW] = AW'($urandom);
            sec_wr_addr[AW*k +: AW] = AW'($urandom);
            sec_mem_out[32*k +: 32] = $urandom;
        end
    endtask

    task automatic wait_done_outs(input int target, input int budget, input string name);
        int i = 0;
        while (done_outs < target && i < budget) begin
            @(posedge clock);
            i++;
        end
        chk(name, 64'(done_outs >= target), 1);
        #1;
    endtask

    task automatic wait_idle();
        int i = 0;
        while ((state_dbg != 2'd0 || pending_dbg != 0) && i < 100) begin
            tick();
            i++;
        end
        chk("idle_reached", {state_dbg, pending_dbg}, 0);
    endtask

    // Monitor + section model: scoreboard on sec_start, done_id follow-up,
    // shared-bus routing, and done pulses after each section's latency.
    task automatic mon_loop();
        int              cnt[NREQ];
        logic            done_chk = 1'b0;
        logic [1:0]      done_chk_id = '0;
        logic [1:0]      id;
        int              o;
        logic [NREQ-1:0] nd;
        for (int k = 0; k < NREQ; k++) cnt[k] = 0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                for (int k = 0; k < NREQ; k++) cnt[k] = 0;
                done_chk = 1'b0;
            end else begin
                if (done_chk) begin
                    chk("done_id_update", done_id, done_chk_id);
                    done_chk = 1'b0;
                end
                o = 0;
                for (int k = 0; k < NREQ; k++) if (grant[k]) o = k;
                if (grant == 0) begin
                    chk("bus_idle_zero", 64'(|{addOutA, addOutB, subOutA, subOutB, L_multOutA,
                        L_multOutB, memReadAddr, memWriteAddr, memOut, memWriteEn}), 0);
                end else if ($countones(grant) == 1) begin
                    chk("bus_arith", {addOutA, addOutB, subOutA, subOutB},
                        {sec_add_a[16*o +: 16], sec_add_b[16*o +: 16],
                         sec_sub_a[16*o +: 16], sec_sub_b[16*o +: 16]});
                    chk("bus_mult_mem", {L_multOutA, L_multOutB, memOut},
                        {sec_mult_a[16*o +: 16], sec_mult_b[16*o +: 16], sec_mem_out[32*o +: 32]});
                    chk("bus_mem_ctl", {memReadAddr, memWriteAddr, memWriteEn},
                        {sec_rd_addr[AW*o +: AW], sec_wr_addr[AW*o +: AW], sec_wr_en[o]});
                end else begin
                    chk("grant_onehot", grant, 0);
                end
                if (sec_done_out) begin
                    done_outs++;
                    done_chk    = 1'b1;
                    done_chk_id = 2'(o);
                    chk("done_out_owner", 64'($countones(grant)), 1);
                end
                if (sec_start != 0) begin
                    starts++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_start", sec_start, 0);
                    end else begin
                        id = exp_q.pop_front();
                        chk("start_id", sec_start, 4'b0001 << id);
                        chk("start_grant", grant, 4'b0001 << id);
                        cnt[id] = hang[id] ? 0 : lat[id];
                    end
                end
            end
            @(posedge clock);
            #2;
            nd = extra_done;
            for (int k = 0; k < NREQ; k++) begin
                if (cnt[k] > 0) begin
                    cnt[k]--;
                    if (cnt[k] == 0) nd[k] = 1'b1;
                end
            end
            sec_done = nd;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int         base, gcnt, bcnt, st, wi;
        logic [1:0] last;

        vecs[0] = '{4'b1111, 4, 8'he4};  // 0,1,2,3
        vecs[1] = '{4'b0100, 1, 8'h02};  // 2
        vecs[2] = '{4'b1001, 2, 8'h03};  // 3,0
        vecs[3] = '{4'b0110, 2, 8'h09};  // 1,2
        vecs[4] = '{4'b0101, 2, 8'h08};  // 0,2
        vecs[5] = '{4'b1010, 2, 8'h07};  // 3,1
        vecs[6] = '{4'b0011, 2, 8'h04};  // 0,1 (wrap from rr_ptr=2)

        reset = 1'b0;
        req = 4'b1111;
        extra_done = '0;
        sec_done = '0;
        sec_wr_en = '0;
        for (int k = 0; k < NREQ; k++) begin
            lat[k] = 1;
            hang[k] = 1'b0;
        end
        randomize_buses();
        fork
            mon_loop();
        join_none

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_state", state_dbg, 0);
        chk("rst_pending", pending_dbg, 0);
        chk("rst_grant", grant, 0);
        chk("rst_pulses", {sec_start, sec_done_out, busy}, 0);
        chk("rst_done_id", done_id, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_mem_we", memWriteEn, 0);
        @(posedge clock);
        #1;
        req = '0;
        reset = 1'b1;

        // Table: request patterns and their round-robin service order
        for (int v = 0; v < 7; v++) begin
            for (int k = 0; k < NREQ; k++) lat[k] = $urandom_range(1, 6);
            sec_wr_en = 4'($urandom_range(0, 15));
            randomize_buses();
            base = done_outs;
            for (int j = 0; j < vecs[v].n; j++) exp_q.push_back(vecs[v].order[2*j +: 2]);
            last = vecs[v].order[2*(vecs[v].n-1) +: 2];
            req = vecs[v].req;
            tick();
            req = '0;
            wait_done_outs(base + vecs[v].n, 200, "vec_all_done");
            chk("vec_last_done_id", done_id, last);
            chk("vec_queue_drained", 64'(exp_q.size()), 0);
            wait_idle();
        end

        // Single request: 2-cycle start latency, 6 grant cycles
        lat[0] = 5;
        exp_q.push_back(2'd0);
        base = done_outs;
        req = 4'b0001;
        tick();
        req = '0;
        @(negedge clock);
        chk("t1_no_early_start", sec_start, 0);
        tick();
        @(negedge clock);
        chk("t1_start_latency", sec_start, 4'b0001);
        gcnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (grant == 4'b0001) gcnt++;
            @(negedge clock);
        end
        chk("t1_grant_cycles", 64'(gcnt), 6);
        chk("t1_done_id", done_id, 0);
        chk("t1_done_out_once", 64'(done_outs - base), 1);
        tick();
        wait_idle();

        // Re-request in the granting cycle, ignored done pulses, no write leak
        lat[1] = 4;
        sec_wr_en = 4'b1101;
        randomize_buses();
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd1);
        base = done_outs;
        req = 4'b0010;
        tick();
        req = 4'b0010;
        tick();
        req = '0;
        extra_done = 4'b0011;
        @(negedge clock);
        chk("t5_start", sec_start, 4'b0010);
        chk("t5_requeued", pending_dbg, 4'b0010);
        tick();
        extra_done = 4'b0001;
        @(negedge clock);
        chk("t5_start_done_ignored", state_dbg, 2);
        chk("t5_no_wr_leak", memWriteEn, 0);
        tick();
        extra_done = '0;
        @(negedge clock);
        chk("t5_non_owner_done_ignored", {state_dbg, grant}, {2'd2, 4'b0010});
        chk("t5_no_early_done_out", 64'(done_outs - base), 0);
        tick();
        wait_done_outs(base + 2, 100, "t5_two_runs");
        chk("t5_done_id", done_id, 1);
        wait_idle();

        // Hung section: watchdog forced release, sticky error, service continues
        hang[2] = 1'b1;
        exp_q.push_back(2'd2);
        base = done_outs;
        chk("t4_err_clear_before", timeout_err, 0);
        req = 4'b0100;
        tick();
        req = '0;
        bcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (state_dbg == 2'd2 && grant == 4'b0100) bcnt++;
        end
        chk("t4_busy_cycles", 64'(bcnt), TIMEOUT);
        chk("t4_timeout_err", timeout_err, 1);
        chk("t4_no_done_out", 64'(done_outs - base), 0);
        hang[2] = 1'b0;
        tick();
        wait_idle();
        lat[3] = 3;
        exp_q.push_back(2'd3);
        req = 4'b1000;
        tick();
        req = '0;
        wait_done_outs(base + 1, 100, "t4_next_served");
        chk("t4_done_id", done_id, 3);
        chk("t4_err_sticky", timeout_err, 1);
        wait_idle();

        // Reset mid-BUSY with two requests pending
        lat[0] = 10;
        exp_q.push_back(2'd0);
        req = 4'b0001;
        tick();
        req = '0;
        wi = 0;
        while (state_dbg != 2'd2 && wi < 10) begin
            @(negedge clock);
            wi++;
        end
        chk("t6_reached_busy", state_dbg, 2);
        tick();
        req = 4'b1010;
        tick();
        req = '0;
        @(negedge clock);
        chk("t6_pending_before", pending_dbg, 4'b1010);
        chk("t6_grant_before", grant, 4'b0001);
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        chk("t6_rst_grant", grant, 0);
        chk("t6_rst_pending", pending_dbg, 0);
        chk("t6_rst_state", {state_dbg, busy}, 0);
        chk("t6_rst_flags", {timeout_err, done_id, sec_start}, 0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        st = starts;
        repeat (12) tick();
        chk("t6_no_start_after_reset", 64'(starts - st), 0);
        chk("final_queue_empty", 64'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
